frame_sequencer: RTL and testbench

- Top-level game controller for JOSH Jump.
- Replaces the menu/game FSM and sequences one game frame per tick:
  - erase the dude sprite at its old position;
  - request one physics/collision update from the datapath;
  - redraw the sprite at its new position.
- Sole driver of the VGA adapter plot interface (160x120, 3-bit colour). Also clears the screen at game start.

---
 rtl/josh_pkg.sv | 26 ++
 rtl/tick_gen.sv | 33 +++
 rtl/frame_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/josh_pkg.sv
// Shared definitions for the JOSH Jump game controller: sequencer states,
// screen geometry, colours and coordinate widths.
package josh_pkg;

   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 7;
   localparam int unsigned COL_W = 3;

   localparam int unsigned SCR_W = 160;
   localparam int unsigned SCR_H = 120;

   localparam logic [COL_W-1:0] BG_COL   = 3'b000;
   localparam logic [COL_W-1:0] DUDE_COL = 3'b111;

   typedef enum logic [2:0] {
      S_MENU,
      S_MENU_WAIT,
      S_CLEAR,
      S_WAIT_TICK,
      S_ERASE,
      S_UPDATE,
      S_DRAW,
      S_OVER
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// Frame tick generator: free-running counter 0..CLK_PER_FRAME-1, tick is high
// for the cycle in which the counter holds CLK_PER_FRAME-1.
// Ports: clk, resetn (sync, active-low), tick (registered, one cycle per frame).
module tick_gen #(
   parameter int unsigned CLK_PER_FRAME = 833333
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(CLK_PER_FRAME);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // tick is registered one count early so it lines up with the terminal count
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         if (r_cnt == CNT_W'(CLK_PER_FRAME - 1))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         r_tick <= (r_cnt == CNT_W'(CLK_PER_FRAME - 2));
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/frame_sequencer.sv
// JOSH Jump top-level game controller. Each frame tick: erase the dude sprite
// at its old position, request one datapath update, redraw at the new position.
// Sole driver of the VGA plot interface; clears the screen at game start.
// Ports: clk, resetn (sync, active-low), go, endgame, upd_done, dude_x/dude_y
//        in; startgame, upd_req, plot, vga_x, vga_y, vga_col, score, overrun
//        out (all registered).
// Build option: define SCORE_EN to enable the frame score counter; otherwise
// score is tied to zero.
module frame_sequencer #(
   parameter int unsigned CLK_PER_FRAME = 833333,
   parameter int unsigned SPR_W         = 4,
   parameter int unsigned SPR_H         = 4,
   parameter int unsigned SCR_W         = josh_pkg::SCR_W,
   parameter int unsigned SCR_H         = josh_pkg::SCR_H,
   parameter logic [2:0]  DUDE_COL      = josh_pkg::DUDE_COL,
   parameter logic [2:0]  BG_COL        = josh_pkg::BG_COL
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     go,
   input  logic                     endgame,
   input  logic                     upd_done,
   input  logic [josh_pkg::X_W-1:0] dude_x,
   input  logic [josh_pkg::Y_W-1:0] dude_y,
   output logic                     startgame,
   output logic                     upd_req,
   output logic                     plot,
   output logic [josh_pkg::X_W-1:0] vga_x,
   output logic [josh_pkg::Y_W-1:0] vga_y,
   output logic [2:0]               vga_col,
   output logic [15:0]              score,
   output logic                     overrun
);
   import josh_pkg::*;

   localparam int unsigned SX_B = $clog2(SPR_W);
   localparam int unsigned SY_B = $clog2(SPR_H);
   localparam int unsigned N_W  = SX_B + SY_B;

   state_t           r_state, w_next_state;
   logic [X_W-1:0]   r_cx, w_cx, r_old_x, w_bx;
   logic [Y_W-1:0]   r_cy, w_cy, r_old_y, w_by;
   logic [N_W-1:0]   r_n, w_n;
   logic             r_pending, w_pending, r_overrun, w_overrun;
   logic             r_plot, w_plot, r_upd_req, w_upd_req, r_startgame, w_startgame;
   logic [X_W-1:0]   r_vga_x, w_vga_x;
   logic [Y_W-1:0]   r_vga_y, w_vga_y;
   logic [COL_W-1:0] r_vga_col, w_vga_col;
   logic             w_latch, w_tick;

   tick_gen #(.CLK_PER_FRAME(CLK_PER_FRAME)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .tick   (w_tick)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_MENU;
         r_cx        <= '0;
         r_cy        <= '0;
         r_n         <= '0;
         r_old_x     <= '0;
         r_old_y     <= '0;
         r_pending   <= 1'b0;
         r_overrun   <= 1'b0;
         r_plot      <= 1'b0;
         r_upd_req   <= 1'b0;
         r_startgame <= 1'b0;
         r_vga_x     <= '0;
         r_vga_y     <= '0;
         r_vga_col   <= '0;
      end else begin
         r_state     <= w_next_state;
         r_cx        <= w_cx;
         r_cy        <= w_cy;
         r_n         <= w_n;
         r_pending   <= w_pending;
         r_overrun   <= w_overrun;
         r_plot      <= w_plot;
         r_upd_req   <= w_upd_req;
         r_startgame <= w_startgame;
         r_vga_x     <= w_vga_x;
         r_vga_y     <= w_vga_y;
         r_vga_col   <= w_vga_col;
         if (w_latch) begin
            r_old_x <= dude_x;
            r_old_y <= dude_y;
         end
      end
   end

   // Next-state, scan counters and next output values
   always_comb begin
      w_next_state = r_state;
      w_cx         = '0;
      w_cy         = '0;
      w_n          = '0;
      w_pending    = r_pending;
      w_overrun    = r_overrun;
      w_plot       = 1'b0;
      w_upd_req    = 1'b0;
      w_vga_x      = r_vga_x;
      w_vga_y      = r_vga_y;
      w_vga_col    = r_vga_col;
      w_latch      = 1'b0;
      // first draw cycle uses the live position, which is being latched then
      w_bx         = (r_state == S_DRAW && r_n == '0) ? dude_x : r_old_x;
      w_by         = (r_state == S_DRAW && r_n == '0) ? dude_y : r_old_y;

      case (r_state)
         S_MENU:      if (go) w_next_state = S_MENU_WAIT;
         S_MENU_WAIT: if (!go) w_next_state = S_CLEAR;
         S_CLEAR: begin
            w_plot    = 1'b1;
            w_vga_x   = r_cx;
            w_vga_y   = r_cy;
            w_vga_col = BG_COL;
            if (r_cx == X_W'(SCR_W - 1)) begin
               if (r_cy == Y_W'(SCR_H - 1)) begin
                  w_pending    = 1'b0;
                  w_next_state = S_DRAW;
               end else begin
                  w_cy = r_cy + Y_W'(1);
               end
            end else begin
               w_cx = r_cx + X_W'(1);
               w_cy = r_cy;
            end
         end
         S_WAIT_TICK: begin
            if (r_pending) begin
               w_pending    = 1'b0;
               w_next_state = S_ERASE;
            end
         end
         S_ERASE, S_DRAW: begin
            w_plot    = 1'b1;
            w_vga_x   = w_bx + X_W'(r_n[SX_B-1:0]);
            w_vga_y   = w_by + Y_W'(r_n[N_W-1:SX_B]);
            w_vga_col = (r_state == S_DRAW) ? DUDE_COL : BG_COL;
            w_latch   = (r_state == S_DRAW) && (r_n == '0);
            if (r_n == '1) begin
               w_next_state = (r_state == S_DRAW) ? S_WAIT_TICK : S_UPDATE;
               // registered, so the pulse lands on the first S_UPDATE cycle
               w_upd_req    = (r_state == S_ERASE);
            end else begin
               w_n = r_n + N_W'(1);
            end
         end
         S_UPDATE: if (upd_done) w_next_state = endgame ? S_OVER : S_DRAW;
         S_OVER:   if (go) w_next_state = S_MENU_WAIT;
         default:  w_next_state = S_MENU;
      endcase

      // a tick that cannot be queued is dropped and flagged
      if (w_tick) begin
         if (r_pending || r_state == S_ERASE || r_state == S_UPDATE || r_state == S_DRAW)
            w_overrun = 1'b1;
         else
            w_pending = 1'b1;
      end

      w_startgame = !(w_next_state == S_MENU || w_next_state == S_MENU_WAIT);
   end

`ifdef SCORE_EN
   logic [15:0] r_score;
   logic        w_clear_last, w_draw_last;

   assign w_clear_last = (r_state == S_CLEAR) && (r_cx == X_W'(SCR_W - 1)) &&
                         (r_cy == Y_W'(SCR_H - 1));
   assign w_draw_last  = (r_state == S_DRAW) && (r_n == '1);

   // Frames survived; restarts when a fresh clear completes, saturates
   always_ff @(posedge clk) begin
      if (!resetn)
         r_score <= '0;
      else if (w_clear_last)
         r_score <= '0;
      else if (w_draw_last && r_score != 16'hFFFF)
         r_score <= r_score + 16'd1;
   end

   assign score = r_score;
`else
   assign score = 16'd0;
`endif

   assign startgame = r_startgame;
   assign upd_req   = r_upd_req;
   assign plot      = r_plot;
   assign vga_x     = r_vga_x;
   assign vga_y     = r_vga_y;
   assign vga_col   = r_vga_col;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer (small screen, short frame period).
module tb_frame_sequencer;

   logic        clk = 1'b0;
   logic        resetn, go, endgame, upd_done;
   logic [7:0]  dude_x, vga_x;
   logic [6:0]  dude_y, vga_y;
   logic        startgame, upd_req, plot, overrun;
   logic [2:0]  vga_col;
   logic [15:0] score;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] col;
   } pix_t;

   pix_t q[$];
   int   upd_cnt = 0;

   typedef struct {
      logic [7:0] dx;      // position the datapath moves the dude to
      logic [6:0] dy;
      int         delay;   // cycles from upd_req to upd_done
      logic       endg;
      logic [7:0] ex;      // expected erase origin
      logic [6:0] ey;
      int         plots;   // expected plot cycles in the frame
      int         score;   // expected score after the frame (when enabled)
   } frame_vec_t;

   frame_sequencer #(
      .CLK_PER_FRAME(64), .SPR_W(4), .SPR_H(4), .SCR_W(8), .SCR_H(4),
      .DUDE_COL(3'b111), .BG_COL(3'b000)
   ) dut (
      .clk(clk), .resetn(resetn), .go(go), .endgame(endgame), .upd_done(upd_done),
      .dude_x(dude_x), .dude_y(dude_y), .startgame(startgame), .upd_req(upd_req),
      .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .vga_col(vga_col),
      .score(score), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Log every plotted pixel and every update request
   always @(posedge clk) begin
      #1;
      if (plot) q.push_back('{x: vga_x, y: vga_y, col: vga_col});
      if (upd_req) upd_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_score(input int v);
`ifdef SCORE_EN
      return 16'(v);
`else
      return 16'd0;
`endif
   endfunction

   function automatic pix_t pix_at(input int i);
      pix_t p;
      p = '1;
      if (i < q.size()) p = q[i];
      return p;
   endfunction

   // Pixels in raster order over the 4x4 sprite at (bx,by)
   function automatic int sprite_bad(input int base, input logic [7:0] bx,
                                     input logic [6:0] by, input logic [2:0] col);
      int   bad = 0;
      pix_t e;
      for (int n = 0; n < 16; n++) begin
         e.x   = bx + 8'(n % 4);
         e.y   = by + 7'(n / 4);
         e.col = col;
         if (pix_at(base + n) !== e) bad++;
      end
      return bad;
   endfunction

   // Full 8x4 screen scan in background colour
   function automatic int clear_bad(input int base);
      int   bad = 0;
      pix_t e;
      for (int n = 0; n < 32; n++) begin
         e.x   = 8'(n % 8);
         e.y   = 7'(n / 8);
         e.col = 3'b000;
         if (pix_at(base + n) !== e) bad++;
      end
      return bad;
   endfunction

   task automatic wait_plots(input int target, input int budget, input string name);
      int i;
      for (i = 0; i < budget && q.size() < target; i++) @(negedge clk);
      if (q.size() < target) check({name, " timeout"}, 64'(q.size()), 64'(target));
   endtask

   task automatic wait_upd_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (upd_req) ok = 1'b1;
      end
      if (!ok) check("upd_req timeout", 64'd0, 64'd1);
   endtask

   frame_vec_t vecs[4];
   bit         ok;
   int         base, bu, qs;

   initial begin
      vecs[0] = '{dx: 8'd3, dy: 7'd1, delay: 5, endg: 1'b0, ex: 8'd2, ey: 7'd1, plots: 32, score: 2};
      vecs[1] = '{dx: 8'd3, dy: 7'd2, delay: 2, endg: 1'b0, ex: 8'd3, ey: 7'd1, plots: 32, score: 3};
      vecs[2] = '{dx: 8'd0, dy: 7'd0, delay: 1, endg: 1'b0, ex: 8'd3, ey: 7'd2, plots: 32, score: 4};
      vecs[3] = '{dx: 8'd0, dy: 7'd0, delay: 3, endg: 1'b1, ex: 8'd0, ey: 7'd0, plots: 16, score: 4};

      resetn = 1'b0; go = 1'b0; endgame = 1'b0; upd_done = 1'b0;
      dude_x = 8'd2; dude_y = 7'd1;
      repeat (3) @(negedge clk);
      check("reset outputs", 64'({startgame, upd_req, plot, vga_x, vga_y, vga_col, score, overrun}), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Start: go held 3 cycles, clear on release, then first draw
      go = 1'b1;
      repeat (3) @(negedge clk);
      check("menu startgame", 64'(startgame), 64'd0);
      go = 1'b0;
      wait_plots(48, 400, "first frame");
      repeat (3) @(negedge clk);
      check("start plot count", 64'(q.size()), 64'd48);
      check("clear scan", 64'(clear_bad(0)), 64'd0);
      check("clear last pixel", 64'(pix_at(31)), 64'({8'd7, 7'd3, 3'b000}));
      check("no upd_req in clear", 64'(upd_cnt), 64'd0);
      check("first draw", 64'(sprite_bad(32, 8'd2, 7'd1, 3'b111)), 64'd0);
      check("first score", 64'(score), 64'(exp_score(1)));
      check("in game", 64'(startgame), 64'd1);

      // Frame vectors
      foreach (vecs[v]) begin
         base = q.size();
         bu   = upd_cnt;
         wait_upd_req(ok);
         dude_x = vecs[v].dx;
         dude_y = vecs[v].dy;
         repeat (vecs[v].delay) @(negedge clk);
         upd_done = 1'b1; endgame = vecs[v].endg;
         @(negedge clk);
         upd_done = 1'b0; endgame = 1'b0;
         if (!vecs[v].endg) wait_plots(base + 32, 200, $sformatf("frame%0d", v));
         repeat (vecs[v].endg ? 20 : 3) @(negedge clk);
         check($sformatf("frame%0d plots", v), 64'(q.size() - base), 64'(vecs[v].plots));
         check($sformatf("frame%0d upd_req", v), 64'(upd_cnt - bu), 64'd1);
         check($sformatf("frame%0d erase", v), 64'(sprite_bad(base, vecs[v].ex, vecs[v].ey, 3'b000)), 64'd0);
         if (vecs[v].plots == 32)
            check($sformatf("frame%0d draw", v), 64'(sprite_bad(base + 16, vecs[v].dx, vecs[v].dy, 3'b111)), 64'd0);
         check($sformatf("frame%0d score", v), 64'(score), 64'(exp_score(vecs[v].score)));
         check($sformatf("frame%0d startgame", v), 64'(startgame), 64'd1);
         check($sformatf("frame%0d plot idle", v), 64'(plot), 64'd0);
         check($sformatf("frame%0d overrun", v), 64'(overrun), 64'd0);
      end

      // Restart from game over: fresh clear, score zero until first draw ends
      base = q.size();
      go = 1'b1;
      repeat (2) @(negedge clk);
      check("restart menu_wait startgame", 64'(startgame), 64'd0);
      go = 1'b0;
      wait_plots(base + 34, 200, "restart clear");
      check("score zero mid-draw", 64'(score), 64'd0);
      wait_plots(base + 48, 100, "restart draw");
      repeat (3) @(negedge clk);
      check("restart clear scan", 64'(clear_bad(base)), 64'd0);
      check("restart draw", 64'(sprite_bad(base + 32, 8'd0, 7'd0, 3'b111)), 64'd0);
      check("restart score", 64'(score), 64'(exp_score(1)));

      // Stalled update: tick lands in S_UPDATE and sets sticky overrun
      wait_upd_req(ok);
      check("overrun before stall", 64'(overrun), 64'd0);
      repeat (70) @(negedge clk);
      check("overrun after stall", 64'(overrun), 64'd1);
      upd_done = 1'b1;
      @(negedge clk);
      upd_done = 1'b0;
      base = q.size();
      wait_plots(base + 4, 50, "stall draw");
      check("overrun sticky", 64'(overrun), 64'd1);

      // Reset in the middle of the draw
      resetn = 1'b0;
      @(negedge clk);
      check("mid-draw reset outputs", 64'({startgame, upd_req, plot, vga_x, vga_y, vga_col, score, overrun}), 64'd0);
      qs = q.size();
      @(negedge clk);
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("no plots after reset", 64'(q.size()), 64'(qs));
      check("menu after reset", 64'(startgame), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
